calc2_multiport_engine: RTL and testbench
=========================================

// Module: calc2_multiport_engine
// PURPOSE
//  Parametrised next-generation multi-port calculator core: NUM_PORTS request ports share one
//  add/sub unit and one shift unit. Two-cycle request protocol per port, per-unit fair
//  (oldest-first) arbitration, overflow/underflow and invalid-command detection, 1-cycle result
//  pulses. Drop-in core for the calc test environment; the bench's reference model is its peer.
// PARAMETERS
//  NUM_PORTS  4   number of request/response ports (>=1)
//  DATA_W     32  operand/result width (power of 2, >=8); SHAMT_W = $clog2(DATA_W)
// PORTS
//  c_clk        in   1                clock; all state changes on posedge
//  reset        in   1                synchronous, active-high reset
//  req_cmd_in   in   4*NUM_PORTS      port p command at [4p+:4]
//  req_data_in  in   DATA_W*NUM_PORTS port p operand at [DATA_W*p+:DATA_W]
//  out_resp     out  2*NUM_PORTS      port p response at [2p+:2]: 0 none,1 ok,2 ovf/invalid,3 unused
//  out_data     out  DATA_W*NUM_PORTS port p result
//  port_busy    out  NUM_PORTS        1 while port p holds an accepted, unanswered command
// BEHAVIOUR
//  - Reset: every output 0; all port FSMs IDLE; both arbitration FIFOs empty; in-flight commands
//    dropped, never answered. Reset mid-operation has identical effect. Inputs ignored in reset.
//  - Commands: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; any other nonzero code = invalid.
//  - Per-port FSM: IDLE -(cmd!=0 at edge E0: latch cmd, opnd1)-> OPND2 -(E1: latch opnd2)->
//    WAIT (valid cmd) or directly drives resp=2,data=0 at E1 and returns IDLE (invalid cmd:
//    no arbitration consumed). WAIT -(grant at edge Eg)-> IDLE with result registered at Eg.
//  - req_cmd_in is ignored while port is OPND2 or WAIT. In the cycle the result is produced (Eg)
//    a new nonzero cmd IS accepted as E0 of the next command (back-to-back overlap).
//  - port_busy=1 from E0 to Eg inclusive of the cycles in between; 0 after Eg unless overlap.
//  - Arbitration: ADD/SUB ports enqueue into arith FIFO, LSH/RSH into shift FIFO, at E1;
//    same-edge enqueues ordered by ascending port index. FIFO depth NUM_PORTS (cannot overflow:
//    <=1 outstanding per port). Each unit grants FIFO head once per cycle; earliest grant is
//    edge E1+1. Arith and shift grants are independent and may coincide.
//  - Latency: uncontended result visible after E2 (2 cycles after command), held 1 cycle.
//  - Response pulse: out_resp/out_data nonzero for exactly one cycle after Eg, then 0; outputs
//    of ports with no result that cycle are 0.
//  - ADD: opnd1+opnd2; carry out of DATA_W -> resp 2, data 0.
//  - SUB: opnd1-opnd2; opnd2>opnd1 -> resp 2, data 0. Equal operands -> resp 1, data 0.
//  - LSH/RSH: opnd1 shifted logically by opnd2[SHAMT_W-1:0]; upper opnd2 bits ignored;
//    zero fill; never overflows; resp 1.
//  - resp 2 always carries data 0. resp 3 never driven.
// TESTING (DATA_W=32, NUM_PORTS=4 unless stated)
//  1 reset; port0 ADD 1,2 -> port0 resp1 data 3 one cycle after E2, then 0; others stay 0.
//  2 ADD FFFFFFFF+1 -> resp2 data 0; SUB 3-5 -> resp2 data 0; SUB 5-5 -> resp1 data 0.
//  3 ports0-3 ADD same cycle; port2 instead LSH 1 by 4 -> port2 resp1 data 0x10 at E2
//    alongside port0; ports1,3 answered at E3,E4 in index order; no port starves.
//  4 cmd 3 on port1 -> resp2 data 0 after E1; simultaneous ADD on port0 still granted at E2.
//  5 LSH 1 by 33 -> data 2; RSH 0x80000000 by 31 -> data 1; RSH by 32 -> data 0x80000000.
//  6 load 4 ADDs, assert reset at E2 for 1 cycle -> all outputs 0, port_busy 0, no stale
//    results afterwards; fresh ADD 7+8 post-reset -> 0xF. Repeat NUM_PORTS=1,8, DATA_W=8.

Source files
------------

// File: rtl/calc2_multiport_engine.sv
// Multi-port calculator core: NUM_PORTS two-cycle request ports share one add/sub unit and
// one shift unit, each fed by an oldest-first FIFO of waiting port indices.
module calc2_multiport_engine #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [NUM_PORTS-1:0]        port_busy
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW      = $clog2(NUM_PORTS + 1);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_OPND2, S_WAIT} state_t;

    // Request protocol: a nonzero command seen by an idle port is taken together with operand 1
    // on that edge; operand 2 is taken unconditionally on the next edge. There is no ready
    // signal -- the requester watches port_busy and must not start a new command while it is 1,
    // except in the cycle the answer is produced, where a new command is accepted.
    state_t                           state_q [NUM_PORTS];
    state_t                           state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][3:0]        cmd_q, cmd_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] op1_q, op1_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] op2_q, op2_d;
    logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0]             busy_q, busy_d;

    // Unit 0 is add/sub, unit 1 is shift; slot 0 of each FIFO is the oldest waiter.
    logic [1:0][NUM_PORTS-1:0][PW-1:0] fifo_q, fifo_d;
    logic [1:0][CW-1:0]                cnt_q, cnt_d;
    logic [1:0][NUM_PORTS-1:0]         enq;

    logic [3:0]                       arith_cmd;
    logic [DATA_W-1:0]                arith_a, arith_b;
    logic [DATA_W:0]                  arith_sum;
    logic [3:0]                       shift_cmd;
    logic [DATA_W-1:0]                shift_a;
    logic [SHAMT_W-1:0]               shift_amt;
    logic [1:0][1:0]                  unit_resp;
    logic [1:0][DATA_W-1:0]           unit_data;
    logic [NUM_PORTS-1:0]             gnt;
    logic [NUM_PORTS-1:0][1:0]        gnt_resp;
    logic [NUM_PORTS-1:0][DATA_W-1:0] gnt_data;

    always_comb begin
        arith_cmd = '0;
        arith_a   = '0;
        arith_b   = '0;
        shift_cmd = '0;
        shift_a   = '0;
        shift_amt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (fifo_q[0][0] == PW'(p)) begin
                arith_cmd = cmd_q[p];
                arith_a   = op1_q[p];
                arith_b   = op2_q[p];
            end
            if (fifo_q[1][0] == PW'(p)) begin
                shift_cmd = cmd_q[p];
                shift_a   = op1_q[p];
                shift_amt = op2_q[p][SHAMT_W-1:0];
            end
        end

        arith_sum = {1'b0, arith_a} + {1'b0, arith_b};
        unit_resp = '0;
        unit_data = '0;
        if (arith_cmd == CMD_SUB) begin
            if (arith_b > arith_a) begin
                unit_resp[0] = RESP_ERR;
            end else begin
                unit_resp[0] = RESP_OK;
                unit_data[0] = arith_a - arith_b;
            end
        end else if (arith_sum[DATA_W]) begin
            unit_resp[0] = RESP_ERR;
        end else begin
            unit_resp[0] = RESP_OK;
            unit_data[0] = arith_sum[DATA_W-1:0];
        end

        unit_resp[1] = RESP_OK;
        if (shift_cmd == CMD_RSH) begin
            unit_data[1] = shift_a >> shift_amt;
        end else begin
            unit_data[1] = shift_a << shift_amt;
        end

        gnt      = '0;
        gnt_resp = '0;
        gnt_data = '0;
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cnt_q[u] != '0 && fifo_q[u][0] == PW'(p)) begin
                    gnt[p]      = 1'b1;
                    gnt_resp[p] = unit_resp[u];
                    gnt_data[p] = unit_data[u];
                end
            end
        end
    end

    always_comb begin
        enq = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            cmd_d[p]   = cmd_q[p];
            op1_d[p]   = op1_q[p];
            op2_d[p]   = op2_q[p];
            resp_d[p]  = RESP_NONE;
            data_d[p]  = '0;
            case (state_q[p])
                S_OPND2: begin
                    op2_d[p] = req_data_in[DATA_W*p +: DATA_W];
                    if (cmd_q[p] == CMD_ADD || cmd_q[p] == CMD_SUB) begin
                        state_d[p] = S_WAIT;
                        enq[0][p]  = 1'b1;
                    end else if (cmd_q[p] == CMD_LSH || cmd_q[p] == CMD_RSH) begin
                        state_d[p] = S_WAIT;
                        enq[1][p]  = 1'b1;
                    end else begin
                        state_d[p] = S_IDLE;
                        resp_d[p]  = RESP_ERR;
                    end
                end
                S_WAIT: begin
                    if (gnt[p]) begin
                        state_d[p] = S_IDLE;
                        resp_d[p]  = gnt_resp[p];
                        data_d[p]  = gnt_data[p];
                    end
                end
                default: begin
                end
            endcase
            // Idle ports, and ports being answered this edge, may start the next command.
            if (state_d[p] == S_IDLE && state_q[p] != S_OPND2 &&
                req_cmd_in[4*p +: 4] != 4'd0) begin
                state_d[p] = S_OPND2;
                cmd_d[p]   = req_cmd_in[4*p +: 4];
                op1_d[p]   = req_data_in[DATA_W*p +: DATA_W];
            end
            busy_d[p] = (state_d[p] != S_IDLE);
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        for (int u = 0; u < 2; u++) begin
            if (cnt_q[u] != '0) begin
                for (int s = 0; s < NUM_PORTS - 1; s++) begin
                    fifo_d[u][s] = fifo_q[u][s+1];
                end
                cnt_d[u] = cnt_q[u] - CW'(1);
            end
            // Ascending port order gives same-edge arrivals a deterministic age.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (enq[u][p]) begin
                    for (int s = 0; s < NUM_PORTS; s++) begin
                        if (CW'(s) == cnt_d[u]) begin
                            fifo_d[u][s] = PW'(p);
                        end
                    end
                    cnt_d[u] = cnt_d[u] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= S_IDLE;
            end
            cmd_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            resp_q <= '0;
            data_q <= '0;
            busy_q <= '0;
            fifo_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
            end
            cmd_q  <= cmd_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            resp_q <= resp_d;
            data_q <= data_d;
            busy_q <= busy_d;
            fifo_q <= fifo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_resp  = resp_q;
    assign out_data  = data_q;
    assign port_busy = busy_q;

endmodule

// File: tb/tb_calc2_multiport_engine.sv
// Bench for calc2_multiport_engine: vector table and random rounds checked through per-port
// expected queues, plus cycle-exact sequences for latency, arbitration, overlap and reset.
module tb_calc2_multiport_engine;
    localparam int NP = 4;
    localparam int W  = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [4*NP-1:0]    req_cmd_in;
    logic [W*NP-1:0]    req_data_in;
    logic [2*NP-1:0]    out_resp;
    logic [W*NP-1:0]    out_data;
    logic [NP-1:0]      port_busy;

    logic [31:0] cmd8;
    logic [63:0] dat8;
    logic [15:0] resp8;
    logic [63:0] odat8;
    logic [7:0]  busy8;
    logic [3:0]  cmd1;
    logic [7:0]  dat1;
    logic [1:0]  resp1;
    logic [7:0]  odat1;
    logic        busy1;

    calc2_multiport_engine #(.NUM_PORTS(NP), .DATA_W(W)) u_dut (
        .c_clk(clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data), .port_busy(port_busy)
    );
    calc2_multiport_engine #(.NUM_PORTS(8), .DATA_W(8)) u_dut8 (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd8), .req_data_in(dat8),
        .out_resp(resp8), .out_data(odat8), .port_busy(busy8)
    );
    calc2_multiport_engine #(.NUM_PORTS(1), .DATA_W(8)) u_dut1 (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd1), .req_data_in(dat1),
        .out_resp(resp1), .out_data(odat1), .port_busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   cmd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   resp;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs [16];

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    logic [W+1:0] exp_q [NP][$];
    logic [3:0]   s_cmd [NP];
    logic [W-1:0] s_a   [NP];
    logic [W-1:0] s_b   [NP];
    logic [W+1:0] s_exp [NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: 64-bit arithmetic for carry, modulo for the shift amount.
    function automatic logic [W+1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [63:0] wide;
        int unsigned sh;
        sh   = b % W;
        wide = 64'(a) + 64'(b);
        case (c)
            4'd1:    return (wide > 64'hFFFF_FFFF) ? {2'd2, {W{1'b0}}} : {2'd1, wide[W-1:0]};
            4'd2:    return (b > a) ? {2'd2, {W{1'b0}}} : {2'd1, a - b};
            4'd5:    return {2'd1, a << sh};
            4'd6:    return {2'd1, a >> sh};
            default: return {2'd2, {W{1'b0}}};
        endcase
    endfunction

    function automatic int pending();
        int n = 0;
        for (int p = 0; p < NP; p++) n += exp_q[p].size();
        return n;
    endfunction

    // Scoreboard: any nonzero port output must match the oldest expectation for that port.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < NP; p++) begin
                if (out_resp[2*p +: 2] != 2'd0 || out_data[W*p +: W] != '0) begin
                    if (exp_q[p].size() == 0)
                        check($sformatf("sb_unexpected_p%0d", p),
                              64'({out_resp[2*p +: 2], out_data[W*p +: W]}), 64'd0);
                    else
                        check($sformatf("sb_result_p%0d", p),
                              64'({out_resp[2*p +: 2], out_data[W*p +: W]}),
                              64'(exp_q[p].pop_front()));
                end
            end
        end
    end

    task automatic clear_set();
        for (int p = 0; p < NP; p++) begin
            s_cmd[p] = '0;
            s_a[p]   = '0;
            s_b[p]   = '0;
            s_exp[p] = '0;
        end
    endtask

    // Drives s_* on all ports at once; returns at the falling edge after E1.
    task automatic issue();
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            req_cmd_in[4*p +: 4] = s_cmd[p];
            req_data_in[W*p +: W] = s_a[p];
            if (s_cmd[p] != 4'd0) exp_q[p].push_back(s_exp[p]);
        end
        @(negedge clk);
        req_cmd_in = '0;
        for (int p = 0; p < NP; p++) req_data_in[W*p +: W] = s_b[p];
        @(negedge clk);
        req_data_in = '0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (pending() != 0 && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_pending", 64'(pending()), 64'd0);
        for (int p = 0; p < NP; p++) exp_q[p].delete();
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return W'($urandom);
            1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            2:       return W'($urandom_range(0, 40));
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_cmd_in = '0;
        req_data_in = '0;
        cmd8 = '0;
        dat8 = '0;
        cmd1 = '0;
        dat1 = '0;
        clear_set();
        vecs[0]  = '{4'd1,  32'd1,          32'd2,          2'd1, 32'd3};
        vecs[1]  = '{4'd1,  32'hFFFF_FFFF,  32'd1,          2'd2, 32'd0};
        vecs[2]  = '{4'd2,  32'd3,          32'd5,          2'd2, 32'd0};
        vecs[3]  = '{4'd2,  32'd5,          32'd5,          2'd1, 32'd0};
        vecs[4]  = '{4'd5,  32'd1,          32'd33,         2'd1, 32'd2};
        vecs[5]  = '{4'd6,  32'h8000_0000,  32'd31,         2'd1, 32'd1};
        vecs[6]  = '{4'd6,  32'h8000_0000,  32'd32,         2'd1, 32'h8000_0000};
        vecs[7]  = '{4'd5,  32'd1,          32'd4,          2'd1, 32'h10};
        vecs[8]  = '{4'd3,  32'd12,         32'd34,         2'd2, 32'd0};
        vecs[9]  = '{4'd15, 32'd1,          32'd1,          2'd2, 32'd0};
        vecs[10] = '{4'd1,  32'd7,          32'd8,          2'd1, 32'hF};
        vecs[11] = '{4'd2,  32'hFFFF_FFFF,  32'd1,          2'd1, 32'hFFFF_FFFE};
        vecs[12] = '{4'd5,  32'hFFFF_FFFF,  32'd31,         2'd1, 32'h8000_0000};
        vecs[13] = '{4'd1,  32'h8000_0000,  32'h8000_0000,  2'd2, 32'd0};
        vecs[14] = '{4'd1,  32'hFFFF_FFFE,  32'd1,          2'd1, 32'hFFFF_FFFF};
        vecs[15] = '{4'd6,  32'hFFFF_FFFF,  32'hFFFF_FFE4,  2'd1, 32'h0FFF_FFFF};

        repeat (3) @(negedge clk);
        check("reset_resp", 64'(out_resp), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_busy", 64'(port_busy), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Basic latency, pulse width and busy window on port 0.
        @(negedge clk);
        req_cmd_in[3:0] = 4'd1;
        req_data_in[31:0] = 32'd1;
        exp_q[0].push_back({2'd1, 32'd3});
        @(negedge clk);
        check("basic_busy_e0", 64'(port_busy), 64'h1);
        req_cmd_in = '0;
        req_data_in[31:0] = 32'd2;
        @(negedge clk);
        check("basic_no_early", 64'(out_resp), 64'd0);
        check("basic_busy_e1", 64'(port_busy), 64'h1);
        req_data_in = '0;
        @(negedge clk);
        check("basic_resp_e2", 64'(out_resp), 64'h01);
        check("basic_data_e2", 64'(out_data[31:0]), 64'd3);
        check("basic_busy_e2", 64'(port_busy), 64'h0);
        @(negedge clk);
        check("basic_pulse_end", 64'(out_resp), 64'd0);
        check("basic_data_end", 64'(out_data), 64'd0);
        wait_drain(4);

        // Vector table, rotating over ports.
        for (int v = 0; v < 16; v++) begin
            clear_set();
            s_cmd[v % NP] = vecs[v].cmd;
            s_a[v % NP]   = vecs[v].a;
            s_b[v % NP]   = vecs[v].b;
            s_exp[v % NP] = {vecs[v].resp, vecs[v].data};
            issue();
            wait_drain(6);
        end

        // Contention: arith grants in index order, shift runs in parallel with port 0.
        clear_set();
        s_cmd[0] = 4'd1; s_a[0] = 32'd5;           s_b[0] = 32'd6;
        s_cmd[1] = 4'd1; s_a[1] = 32'd1000;        s_b[1] = 32'd1;
        s_cmd[2] = 4'd5; s_a[2] = 32'd1;           s_b[2] = 32'd4;
        s_cmd[3] = 4'd1; s_a[3] = 32'hFFFF_FFF0;   s_b[3] = 32'h0F;
        for (int p = 0; p < NP; p++) s_exp[p] = model(s_cmd[p], s_a[p], s_b[p]);
        issue();
        @(negedge clk);
        check("arb_resp_e2", 64'(out_resp), 64'h11);
        check("arb_shift_data_e2", 64'(out_data[95:64]), 64'h10);
        check("arb_busy_e2", 64'(port_busy), 64'hA);
        @(negedge clk);
        check("arb_resp_e3", 64'(out_resp), 64'h04);
        check("arb_busy_e3", 64'(port_busy), 64'h8);
        @(negedge clk);
        check("arb_resp_e4", 64'(out_resp), 64'h40);
        check("arb_data_e4", 64'(out_data[127:96]), 64'hFFFF_FFFF);
        check("arb_busy_e4", 64'(port_busy), 64'h0);
        wait_drain(4);

        // Invalid command answered at E1 without delaying a concurrent ADD.
        clear_set();
        s_cmd[0] = 4'd1; s_a[0] = 32'd20; s_b[0] = 32'd22; s_exp[0] = {2'd1, 32'd42};
        s_cmd[1] = 4'd3; s_a[1] = 32'd9;  s_b[1] = 32'd9;  s_exp[1] = {2'd2, 32'd0};
        issue();
        check("inv_resp_e1", 64'(out_resp), 64'h08);
        check("inv_busy_e1", 64'(port_busy), 64'h1);
        @(negedge clk);
        check("inv_add_resp_e2", 64'(out_resp), 64'h01);
        wait_drain(4);

        // Back-to-back overlap; a command during OPND2 must be ignored.
        @(negedge clk);
        req_cmd_in[3:0] = 4'd1;
        req_data_in[31:0] = 32'd10;
        exp_q[0].push_back({2'd1, 32'd30});
        @(negedge clk);
        req_cmd_in[3:0] = 4'd6;
        req_data_in[31:0] = 32'd20;
        @(negedge clk);
        req_cmd_in[3:0] = 4'd1;
        req_data_in[31:0] = 32'd100;
        exp_q[0].push_back({2'd1, 32'd105});
        @(negedge clk);
        check("ovl_first_resp", 64'(out_resp), 64'h01);
        check("ovl_first_data", 64'(out_data[31:0]), 64'd30);
        check("ovl_busy_kept", 64'(port_busy), 64'h1);
        req_cmd_in = '0;
        req_data_in[31:0] = 32'd5;
        @(negedge clk);
        check("ovl_gap", 64'(out_resp), 64'd0);
        req_data_in = '0;
        @(negedge clk);
        check("ovl_second_resp", 64'(out_resp), 64'h01);
        check("ovl_second_data", 64'(out_data[31:0]), 64'd105);
        check("ovl_busy_done", 64'(port_busy), 64'h0);
        wait_drain(4);

        // Random rounds with all ports competing.
        for (int r = 0; r < 24; r++) begin
            clear_set();
            for (int p = 0; p < NP; p++) begin
                case ($urandom_range(0, 6))
                    0: s_cmd[p] = 4'd0;
                    1: s_cmd[p] = 4'd1;
                    2: s_cmd[p] = 4'd2;
                    3: s_cmd[p] = 4'd5;
                    4: s_cmd[p] = 4'd6;
                    5: s_cmd[p] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(3, 4))
                                                             : 4'($urandom_range(7, 15));
                    default: s_cmd[p] = 4'd1;
                endcase
                s_a[p]   = pick_operand();
                s_b[p]   = pick_operand();
                s_exp[p] = model(s_cmd[p], s_a[p], s_b[p]);
            end
            issue();
            wait_drain(NP + 4);
        end

        // Reset at E2 with four commands in flight: nothing may surface afterwards.
        clear_set();
        for (int p = 0; p < NP; p++) begin
            s_cmd[p] = 4'd1;
            s_a[p]   = W'(p + 1);
            s_b[p]   = 32'd100;
            s_exp[p] = model(s_cmd[p], s_a[p], s_b[p]);
        end
        issue();
        reset = 1'b1;
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_resp", 64'(out_resp), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        check("rst_mid_busy", 64'(port_busy), 64'd0);
        repeat (8) @(negedge clk);
        check("rst_stay_idle", 64'(port_busy), 64'd0);
        clear_set();
        s_cmd[0] = 4'd1; s_a[0] = 32'd7; s_b[0] = 32'd8; s_exp[0] = {2'd1, 32'hF};
        issue();
        @(negedge clk);
        check("rst_fresh_data", 64'(out_data[31:0]), 64'hF);
        wait_drain(4);

        // Eight ports, 8-bit data: strict index-order service; single-port 8-bit overflow.
        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            cmd8[4*p +: 4] = 4'd1;
            dat8[8*p +: 8] = 8'(p + 1);
        end
        cmd1 = 4'd1;
        dat1 = 8'd200;
        @(negedge clk);
        cmd8 = '0;
        for (int p = 0; p < 8; p++) dat8[8*p +: 8] = 8'd10;
        cmd1 = '0;
        dat1 = 8'd100;
        @(negedge clk);
        dat8 = '0;
        dat1 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("p8_resp_k%0d", k), 64'(resp8), 64'(16'h1 << (2*k)));
            check($sformatf("p8_data_k%0d", k), odat8, 64'(k + 11) << (8*k));
            if (k == 0) check("p1_ovf", 64'({resp1, odat1}), 64'h200);
        end
        @(negedge clk);
        check("p8_idle", 64'({resp8, busy8}), 64'd0);

        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            cmd8[4*p +: 4] = 4'd1;
            dat8[8*p +: 8] = 8'd3;
        end
        cmd1 = 4'd1;
        dat1 = 8'd7;
        @(negedge clk);
        cmd8 = '0;
        for (int p = 0; p < 8; p++) dat8[8*p +: 8] = 8'd4;
        cmd1 = '0;
        dat1 = 8'd8;
        @(negedge clk);
        dat8 = '0;
        dat1 = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("small_rst_out", 64'({resp8, resp1}), 64'd0);
        check("small_rst_busy", 64'({busy8, busy1}), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("small_no_stale", 64'({resp8, resp1, odat1}), 64'd0);
        end
        @(negedge clk);
        cmd8[31:28] = 4'd1;
        dat8[63:56] = 8'd250;
        cmd1 = 4'd1;
        dat1 = 8'd7;
        @(negedge clk);
        cmd8 = '0;
        dat8[63:56] = 8'd10;
        cmd1 = '0;
        dat1 = 8'd8;
        @(negedge clk);
        dat8 = '0;
        dat1 = '0;
        @(negedge clk);
        check("p8_post_rst_ovf", 64'(resp8), 64'h8000);
        check("p8_post_rst_data", odat8, 64'd0);
        check("p1_post_rst_add", 64'({resp1, odat1}), 64'h10F);

        @(negedge clk);
        check("final_pending", 64'(pending()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
